mig_cmd_arbiter: RTL



---
 rtl/mig_arb_pkg.sv | 38 +++
 rtl/mig_cmd_out_reg.sv | 45 ++++
 rtl/mig_cmd_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mig_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mig_arb_pkg
//  Description : Shared types and constants for the MIG command arbiter:
//                arbiter state encoding and the registered command record.
//  Revision    : 1.0  initial release
// ============================================================================
package mig_arb_pkg;

    // MIG user-interface widths
    localparam int MIG_DATA_W = 128;
    localparam int MIG_STRB_W = 16;
    // Address field of the command record; the arbiter's ADDR_WIDTH must not
    // exceed this (the record is sized for the widest supported part).
    localparam int MIG_ADDR_W = 27;

    // Arbiter states
    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_WR_GRANT = 2'd1,
        ARB_RD_GRANT = 2'd2
    } arb_state_e;

    // Flat constants used by the FSM register
    localparam logic [1:0] C_ST_IDLE     = 2'(ARB_IDLE);
    localparam logic [1:0] C_ST_WR_GRANT = 2'(ARB_WR_GRANT);
    localparam logic [1:0] C_ST_RD_GRANT = 2'(ARB_RD_GRANT);

    // One MIG command as held in the output stage
    typedef struct packed {
        logic                  write;
        logic [MIG_ADDR_W-1:0] addr;
        logic [MIG_DATA_W-1:0] data;
        logic [MIG_STRB_W-1:0] strobe;
    } mig_cmd_t;

endpackage : mig_arb_pkg
`default_nettype wire

// File: rtl/mig_cmd_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mig_cmd_out_reg
//  Description : Single valid/ready register stage for MIG commands. Accepts a
//                new command whenever the stage is empty or being drained in
//                the same cycle, so a full stage still sustains one command
//                per clock.
//  Revision    : 1.0  initial release
// ============================================================================
module mig_cmd_out_reg
    import mig_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_valid,
    output logic     o_ready,
    input  mig_cmd_t i_cmd,
    output logic     o_valid,
    input  logic     i_ready,
    output mig_cmd_t o_cmd
);

    logic     r_valid;
    mig_cmd_t r_cmd;

    // Stage can take a command when empty or when its content leaves this cycle
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_cmd   = r_cmd;

    // Load/drain the stage; contents are frozen while stalled downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_cmd   <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_cmd <= i_cmd;
            end
        end
    end

endmodule : mig_cmd_out_reg
`default_nettype wire

// File: rtl/mig_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mig_cmd_arbiter
//  Description : Shares the MIG command/write-data path between the
//                framebuffer write stream and the display read stream.
//                One requester is granted at a time; burst limits bound each
//                grant so neither side starves, and an urgent display read
//                preempts writes. One registered command stage drives the
//                MIG command FIFO.
//  Options     : MIG_ARB_ZERO_STROBE_DROP_EN - when defined, write beats with
//                an all-zero strobe are accepted and counted but never
//                forwarded to the MIG.
//  Revision    : 1.0  initial release
// ============================================================================
module mig_cmd_arbiter
    import mig_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 27,
    parameter int WR_BURST_MAX = 8,
    parameter int RD_BURST_MAX = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    // framebuffer write stream
    input  logic                  wr_valid_in,
    output logic                  wr_rdy_out,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [MIG_DATA_W-1:0] wr_data_in,
    input  logic [MIG_STRB_W-1:0] wr_strobe_in,
    // display read stream
    input  logic                  rd_valid_in,
    output logic                  rd_rdy_out,
    input  logic [ADDR_WIDTH-1:0] rd_addr_in,
    input  logic                  rd_urgent_in,
    // MIG command FIFO side
    output logic                  cmd_valid_out,
    input  logic                  cmd_rdy_in,
    output logic                  cmd_write_out,
    output logic [ADDR_WIDTH-1:0] cmd_addr_out,
    output logic [MIG_DATA_W-1:0] cmd_data_out,
    output logic [MIG_STRB_W-1:0] cmd_strobe_out
);

    localparam int C_BURST_MAX = (WR_BURST_MAX > RD_BURST_MAX) ? WR_BURST_MAX : RD_BURST_MAX;
    localparam int C_CNT_W     = $clog2(C_BURST_MAX) + 1;

    localparam logic [C_CNT_W-1:0] C_WR_LIMIT = C_CNT_W'(WR_BURST_MAX);
    localparam logic [C_CNT_W-1:0] C_RD_LIMIT = C_CNT_W'(RD_BURST_MAX);
    localparam logic [C_CNT_W-1:0] C_CNT_SAT  = {C_CNT_W{1'b1}};

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [C_CNT_W-1:0] r_burst_cnt;
    logic [C_CNT_W-1:0] w_cnt_acc;

    logic     w_out_free;
    logic     w_wr_acc;
    logic     w_rd_acc;
    logic     w_wr_load;
    logic     w_stage_load;
    mig_cmd_t w_in_cmd;
    mig_cmd_t w_out_cmd;

    // Handshakes: only the granted side sees ready, and only when the
    // output stage can take a command this cycle
    assign wr_rdy_out = (r_state == C_ST_WR_GRANT) && w_out_free;
    assign rd_rdy_out = (r_state == C_ST_RD_GRANT) && w_out_free;
    assign w_wr_acc   = wr_valid_in && wr_rdy_out;
    assign w_rd_acc   = rd_valid_in && rd_rdy_out;

`ifdef MIG_ARB_ZERO_STROBE_DROP_EN
    // A beat that writes no bytes is consumed but never reaches the MIG
    assign w_wr_load = w_wr_acc && (wr_strobe_in != '0);
`else
    assign w_wr_load = w_wr_acc;
`endif

    assign w_stage_load = w_wr_load || w_rd_acc;

    // Beat count including this cycle's accept; saturates instead of wrapping
    always_comb begin
        w_cnt_acc = r_burst_cnt;
        if ((w_wr_acc || w_rd_acc) && (r_burst_cnt != C_CNT_SAT)) begin
            w_cnt_acc = r_burst_cnt + 1'b1;
        end
    end

    // Command record for whichever side is accepted; reads carry no data
    always_comb begin
        w_in_cmd = '0;
        if (w_wr_acc) begin
            w_in_cmd.write  = 1'b1;
            w_in_cmd.addr   = MIG_ADDR_W'(wr_addr_in);
            w_in_cmd.data   = wr_data_in;
            w_in_cmd.strobe = wr_strobe_in;
        end else begin
            w_in_cmd.write  = 1'b0;
            w_in_cmd.addr   = MIG_ADDR_W'(rd_addr_in);
        end
    end

    // Grant selection, evaluated after this cycle's accept has been counted
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (rd_valid_in && (rd_urgent_in || !wr_valid_in)) begin
                    w_state_nxt = C_ST_RD_GRANT;
                end else if (wr_valid_in) begin
                    w_state_nxt = C_ST_WR_GRANT;
                end
            end
            C_ST_WR_GRANT: begin
                if (rd_valid_in && (rd_urgent_in || (w_cnt_acc >= C_WR_LIMIT) || !wr_valid_in)) begin
                    w_state_nxt = C_ST_RD_GRANT;
                end else if (!wr_valid_in && !rd_valid_in) begin
                    w_state_nxt = C_ST_IDLE;
                end
            end
            C_ST_RD_GRANT: begin
                // Urgency pins the grant on reads regardless of burst length
                if (wr_valid_in && !rd_urgent_in && ((w_cnt_acc >= C_RD_LIMIT) || !rd_valid_in)) begin
                    w_state_nxt = C_ST_WR_GRANT;
                end else if (!wr_valid_in && !rd_valid_in) begin
                    w_state_nxt = C_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = C_ST_IDLE;
            end
        endcase
    end

    // State and burst counter; the counter restarts on every grant change
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= C_ST_IDLE;
            r_burst_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_burst_cnt <= '0;
            end else begin
                r_burst_cnt <= w_cnt_acc;
            end
        end
    end

    mig_cmd_out_reg u_out_reg (
        .clk     (clk_in),
        .rst     (rst_in),
        .i_valid (w_stage_load),
        .o_ready (w_out_free),
        .i_cmd   (w_in_cmd),
        .o_valid (cmd_valid_out),
        .i_ready (cmd_rdy_in),
        .o_cmd   (w_out_cmd)
    );

    assign cmd_write_out  = w_out_cmd.write;
    assign cmd_addr_out   = ADDR_WIDTH'(w_out_cmd.addr);
    assign cmd_data_out   = w_out_cmd.data;
    assign cmd_strobe_out = w_out_cmd.strobe;

endmodule : mig_cmd_arbiter
`default_nettype wire
